// File: rtl/wide_word_splitter.sv
// wide_word_splitter: buffers 64-bit packed words in a FIFO and re-issues
// each word as four 16-bit beats (LSB half-word first) on valid/ready.
// Ports: clk, rst (sync, active-high); i_data/i_vld producer side (no
// stall); o_data/o_vld/o_last/i_rdy beat stream; o_level FIFO occupancy
// (excluding the output stage); o_ovf sticky overflow; o_drop_cnt dropped
// words (built only when WIDE_SPLIT_DROP_CNT_EN is defined, else 0).
module wide_word_splitter #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [63:0]              i_data,
    input  logic                     i_vld,
    output logic [15:0]              o_data,
    output logic                     o_vld,
    output logic                     o_last,
    input  logic                     i_rdy,
    output logic [$clog2(DEPTH):0]   o_level,
    output logic                     o_ovf,
    output logic [7:0]               o_drop_cnt
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic {IDLE, SEND} state_t;

    logic [63:0] mem [DEPTH];
    logic [AW:0] wptr, rptr;
    logic        empty, full, push, pop, drop;
    logic [63:0] head;
    state_t      state;
    logic [63:0] word;
    logic [1:0]  beat;
    logic [1:0]  nxt;

    assign empty = (wptr == rptr);
    assign full  = (wptr[AW] != rptr[AW]) &&
                   (wptr[AW-1:0] == rptr[AW-1:0]);
    assign head  = mem[rptr[AW-1:0]];
    assign nxt   = beat + 2'd1;

    // Pop either to fill an idle stage or to chain the next word
    // behind beat 3 without a bubble.
    assign pop  = !empty &&
                  ((state == IDLE) ||
                   (i_rdy && beat == 2'd3));
    // A pop in the same cycle frees the slot a full FIFO needs.
    assign push = i_vld && (!full || pop);
    assign drop = i_vld && full && !pop;

    always_ff @(posedge clk) begin
        if (push)
            mem[wptr[AW-1:0]] <= i_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr    <= '0;
            rptr    <= '0;
            o_level <= '0;
            o_ovf   <= 1'b0;
        end else begin
            if (push)
                wptr <= wptr + 1'b1;
            if (pop)
                rptr <= rptr + 1'b1;
            if (push && !pop)
                o_level <= o_level + 1'b1;
            else if (pop && !push)
                o_level <= o_level - 1'b1;
            if (drop)
                o_ovf <= 1'b1;
        end
    end

`ifdef WIDE_SPLIT_DROP_CNT_EN
    always_ff @(posedge clk) begin
        if (rst)
            o_drop_cnt <= '0;
        else if (drop && o_drop_cnt != 8'hFF)
            o_drop_cnt <= o_drop_cnt + 8'd1;
    end
`else
    assign o_drop_cnt = '0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            word   <= '0;
            beat   <= '0;
            o_data <= '0;
            o_vld  <= 1'b0;
            o_last <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (!empty) begin
                        state  <= SEND;
                        word   <= head;
                        beat   <= '0;
                        o_data <= head[15:0];
                        o_vld  <= 1'b1;
                        o_last <= 1'b0;
                    end
                end
                SEND: begin
                    if (i_rdy) begin
                        if (beat != 2'd3) begin
                            beat   <= nxt;
                            o_data <= word[{nxt, 4'b0} +: 16];
                            o_last <= (nxt == 2'd3);
                        end else if (!empty) begin
                            word   <= head;
                            beat   <= '0;
                            o_data <= head[15:0];
                            o_last <= 1'b0;
                        end else begin
                            state  <= IDLE;
                            beat   <= '0;
                            o_vld  <= 1'b0;
                            o_last <= 1'b0;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_wide_word_splitter.sv
// tb_wide_word_splitter: directed self-checking bench for
// wide_word_splitter (DEPTH=4) using immediate assertions.
module tb_wide_word_splitter;
    logic        clk = 1'b0;
    logic        rst;
    logic [63:0] i_data;
    logic        i_vld;
    logic [15:0] o_data;
    logic        o_vld;
    logic        o_last;
    logic        i_rdy;
    logic [2:0]  o_level;
    logic        o_ovf;
    logic [7:0]  o_drop_cnt;

    int n_tests = 0;
    int n_fail  = 0;
    logic [63:0] wq [6];
    logic [7:0]  exp_drop;

    wide_word_splitter #(.DEPTH(4)) dut (
        .clk(clk), .rst(rst),
        .i_data(i_data), .i_vld(i_vld),
        .o_data(o_data), .o_vld(o_vld), .o_last(o_last),
        .i_rdy(i_rdy), .o_level(o_level),
        .o_ovf(o_ovf), .o_drop_cnt(o_drop_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag,
                       input logic [63:0] obs,
                       input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] bt(input logic [63:0] w,
                                       input int k);
        return w[16*k +: 16];
    endfunction

    // Runs the sink at i_rdy=1 for a fixed window, checking every
    // accepted beat against wq[] from beat index 'from' up to 'upto'.
    task automatic drain(input string tag, input int from,
                         input int upto);
        int nb = from;
        i_rdy = 1'b1;
        for (int cy = 0; cy < 40; cy++) begin
            if (o_vld) begin
                if (nb < upto) begin
                    chk({tag, "_data"}, 64'(o_data),
                        64'(bt(wq[nb/4], nb%4)));
                    chk({tag, "_last"}, 64'(o_last),
                        64'(nb%4 == 3));
                end
                nb++;
            end
            tick();
        end
        chk({tag, "_count"}, 64'(nb), 64'(upto));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        i_vld = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        i_data = '0;
        i_vld = 1'b0;
        i_rdy = 1'b0;
`ifdef WIDE_SPLIT_DROP_CNT_EN
        exp_drop = 8'd1;
`else
        exp_drop = 8'd0;
`endif
        tick();
        tick();
        chk("rst_data", 64'(o_data), 64'h0);
        chk("rst_vld", 64'(o_vld), 64'h0);
        chk("rst_last", 64'(o_last), 64'h0);
        chk("rst_level", 64'(o_level), 64'h0);
        chk("rst_ovf", 64'(o_ovf), 64'h0);
        chk("rst_drop", 64'(o_drop_cnt), 64'h0);
        rst = 1'b0;

        // Single word, sink always ready: beats at c+2..c+5.
        i_rdy = 1'b1;
        i_data = 64'h0123_4567_89AB_CDEF;
        i_vld = 1'b1;
        tick();
        i_vld = 1'b0;
        chk("w1_c1_vld", 64'(o_vld), 64'h0);
        chk("w1_c1_level", 64'(o_level), 64'h1);
        tick();
        chk("w1_b0_vld", 64'(o_vld), 64'h1);
        chk("w1_b0", 64'(o_data), 64'hCDEF);
        chk("w1_b0_last", 64'(o_last), 64'h0);
        chk("w1_b0_level", 64'(o_level), 64'h0);
        tick();
        chk("w1_b1", 64'(o_data), 64'h89AB);
        chk("w1_b1_last", 64'(o_last), 64'h0);
        tick();
        chk("w1_b2", 64'(o_data), 64'h4567);
        chk("w1_b2_last", 64'(o_last), 64'h0);
        tick();
        chk("w1_b3", 64'(o_data), 64'h0123);
        chk("w1_b3_last", 64'(o_last), 64'h1);
        chk("w1_b3_vld", 64'(o_vld), 64'h1);
        tick();
        chk("w1_done_vld", 64'(o_vld), 64'h0);
        chk("w1_done_last", 64'(o_last), 64'h0);

        // Two back-to-back words: 8 gapless beats, last at c+5, c+9.
        wq[0] = 64'h1111_2222_3333_4444;
        wq[1] = 64'hAAAA_BBBB_CCCC_DDDD;
        i_data = wq[0];
        i_vld = 1'b1;
        tick();
        i_data = wq[1];
        tick();
        i_vld = 1'b0;
        for (int k = 0; k < 8; k++) begin
            chk("b2b_vld", 64'(o_vld), 64'h1);
            chk("b2b_data", 64'(o_data), 64'(bt(wq[k/4], k%4)));
            chk("b2b_last", 64'(o_last), 64'(k == 3 || k == 7));
            tick();
        end
        chk("b2b_end_vld", 64'(o_vld), 64'h0);

        // Sink toggling ready: each beat held while stalled.
        wq[0] = 64'hFEDC_BA98_7654_3210;
        i_data = wq[0];
        i_vld = 1'b1;
        tick();
        i_vld = 1'b0;
        tick();
        begin
            int k = 0;
            for (int cy = 0; cy < 14; cy++) begin
                i_rdy = (cy % 2 == 0);
                if (o_vld) begin
                    chk("tog_data", 64'(o_data),
                        64'(bt(wq[0], k)));
                    chk("tog_last", 64'(o_last), 64'(k == 3));
                    if (i_rdy)
                        k++;
                end
                tick();
            end
            chk("tog_count", 64'(k), 64'd4);
        end
        chk("tog_end_vld", 64'(o_vld), 64'h0);

        // Overflow: sink stalled, 6 pushes, 5 kept, 6th dropped.
        i_rdy = 1'b0;
        for (int i = 0; i < 6; i++) begin
            wq[i] = {16'(i), 16'h5A00 + 16'(i),
                     16'hC300 + 16'(i), 16'h0F00 + 16'(i)};
            i_data = wq[i];
            i_vld = 1'b1;
            tick();
        end
        i_vld = 1'b0;
        chk("ovf_level", 64'(o_level), 64'd4);
        chk("ovf_flag", 64'(o_ovf), 64'h1);
        chk("ovf_drop", 64'(o_drop_cnt), 64'(exp_drop));
        drain("ovf_drain", 0, 20);
        chk("ovf_sticky", 64'(o_ovf), 64'h1);
        chk("ovf_level0", 64'(o_level), 64'd0);

        // Full FIFO: push coincides with pop on beat 3.
        do_reset();
        chk("rst2_ovf", 64'(o_ovf), 64'h0);
        i_rdy = 1'b0;
        for (int i = 0; i < 6; i++)
            wq[i] = {16'h7000 + 16'(i), 16'h6000 + 16'(i),
                     16'h5000 + 16'(i), 16'h4000 + 16'(i)};
        for (int i = 0; i < 5; i++) begin
            i_data = wq[i];
            i_vld = 1'b1;
            tick();
        end
        i_vld = 1'b0;
        chk("full_level", 64'(o_level), 64'd4);
        i_rdy = 1'b1;
        tick();
        tick();
        tick();
        chk("full_b3_last", 64'(o_last), 64'h1);
        i_data = wq[5];
        i_vld = 1'b1;
        tick();
        i_vld = 1'b0;
        chk("full_ovf", 64'(o_ovf), 64'h0);
        chk("full_level_kept", 64'(o_level), 64'd4);
        drain("full_drain", 4, 24);
        chk("full_drop", 64'(o_drop_cnt), 64'h0);

        // Reset mid-word with two words buffered.
        do_reset();
        i_rdy = 1'b1;
        for (int i = 0; i < 3; i++) begin
            wq[i] = {16'hE000 + 16'(i), 16'hD000 + 16'(i),
                     16'hB000 + 16'(i), 16'hA000 + 16'(i)};
            i_data = wq[i];
            i_vld = 1'b1;
            tick();
        end
        i_vld = 1'b0;
        chk("mid_b1", 64'(o_data), 64'(bt(wq[0], 1)));
        chk("mid_level", 64'(o_level), 64'd2);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_vld", 64'(o_vld), 64'h0);
        chk("mid_level0", 64'(o_level), 64'd0);
        tick();
        chk("mid_idle", 64'(o_vld), 64'h0);
        wq[0] = 64'h0BAD_F00D_CAFE_BEEF;
        i_data = wq[0];
        i_vld = 1'b1;
        tick();
        i_vld = 1'b0;
        tick();
        chk("post_vld", 64'(o_vld), 64'h1);
        chk("post_b0", 64'(o_data), 64'hBEEF);
        chk("post_last", 64'(o_last), 64'h0);
        drain("post_drain", 0, 4);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
